dts_verifier: RTL
=================

DTS_VERIFIER -- requirements
Module: dts_verifier

Interface
REQ-001 SHALL have parameter n, default 3, meaning the number of rulers (blocks) in the set.
REQ-002 SHALL have parameter M, default 19, meaning the largest mark value.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset; it is asynchronous and active-low.
REQ-005 SHALL have port start  input  1  meaning a request to check res_in; it is sampled only in IDLE.
REQ-006 SHALL have port res_in  input  n*(M+1)  meaning the mark bitmaps; row r occupies bits [r*(M+1)+M : r*(M+1)], and bit r*(M+1)+i set means mark i.
REQ-007 SHALL have port busy  output  1  meaning a check is in progress.
REQ-008 SHALL have port done  output  1  meaning a one-cycle pulse when a check completes.
REQ-009 SHALL have port valid  output  1  meaning the last checked set is a valid DTS.
REQ-010 SHALL have port errCode  output  2  with values 0 ok, 1 repeated difference, 2 a row lacks mark 0.
REQ-011 SHALL have port errRow  output  clog2(n)  meaning the offending row.
REQ-012 SHALL have port errDiff  output  clog2(M+1)  meaning the repeated difference, or 0 when not applicable.

Function
REQ-013 SHALL implement the FSM states IDLE, SCAN and DONE, all registered.
REQ-014 SHALL, in IDLE with start=1 at edge k, capture res_in into an internal snapshot and clear the seen[1..M] bitmap.
REQ-015 SHALL, at that same edge k, go to DONE with errCode=2 and errRow set to the lowest row lacking mark 0, if any such row exists.
REQ-016 SHALL otherwise, at edge k, go to SCAN with pair (r=0, i=0, j=1), and busy SHALL go to 1.
REQ-017 SHALL, in SCAN, evaluate exactly one pair (r,i,j) per cycle, walking j from i+1 to M, then i from 0 to M-1, then r from 0 to n-1.
REQ-018 SHALL skip a pair (no effect) unless both mark i and mark j of row r are set.
REQ-019 SHALL, for a pair where both marks are set, compute d=j-i, with d always in 1..M.
REQ-020 SHALL, for such a pair, go to DONE with errCode=1, errRow=r and errDiff=d if seen[d]=1; otherwise it SHALL set seen[d].
REQ-021 SHALL give a total of N=n*M*(M+1)/2 pairs, which is 570 at the defaults.
REQ-022 SHALL evaluate pair index p at edge k+p+1; the last pair is evaluated at edge k+N and then enters DONE with errCode=0.
REQ-023 SHALL check differences globally across all rows, not per row.
REQ-024 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE; busy SHALL be 0 in DONE.
REQ-025 SHALL set valid=1 only when errCode=0.
REQ-026 SHALL hold valid, errCode, errRow and errDiff from DONE until the next accepted start.
REQ-027 SHALL clear valid, errCode, errRow and errDiff at an accepted start.
REQ-028 SHALL ignore start in SCAN and in DONE, and SHALL ignore changes to res_in after capture.
REQ-029 SHALL accept a row containing only mark 0 as valid, since it contributes no differences.
REQ-030 SHALL use counters sized to hold M and n-1, with no wrap-around within a scan.

Reset
REQ-031 SHALL, while reset=0 and asynchronously, force state IDLE, busy=0, done=0, valid=0, errCode=0, errRow=0, errDiff=0 and seen=0.
REQ-032 SHALL treat a reset mid-SCAN as an abandoned check: no done pulse, and outputs as in REQ-031.
REQ-033 SHALL accept start on the first rising edge with reset=1.

Verification
REQ-034 SHALL cover: rows {0,1},{0,2},{0,3} (bits 0,1,20,22,40,43), start at edge k -> done at the cycle after edge k+570, valid=1, errCode=0.
REQ-035 SHALL cover: row0 {0,1,3}, row1 {0,2}, row2 {0} -> done after edge k+192, errCode=1, errRow=1, errDiff=2, valid=0.
REQ-036 SHALL cover: row2 {5,7} with other rows valid -> done after edge k, errCode=2, errRow=2, busy never 1.
REQ-037 SHALL cover: all rows {0} only -> done after edge k+570, valid=1.
REQ-038 SHALL cover: start held high throughout SCAN and DONE -> a single check with a single done pulse; the next check begins from IDLE only.
REQ-039 SHALL cover: reset=0 pulsed at edge k+100 of a scan -> all outputs 0 immediately, no done; a later start gives the normal REQ-034 result.

Source files
------------

// File: rtl/dts_verifier.sv
// Difference-triangle-set checker. Captures n rulers of marks 0..M and walks every
// mark pair of every row, one pair per cycle, flagging the first difference that
// repeats anywhere in the set or any row that lacks mark 0.
module dts_verifier #(
  parameter int n = 3,
  parameter int M = 19
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [n*(M+1)-1:0]                      res_in,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    valid,
  output logic [1:0]                              errCode,
  output logic [((n > 1) ? $clog2(n) : 1)-1:0]    errRow,
  output logic [$clog2(M+1)-1:0]                  errDiff
);

  localparam int RW = (n > 1) ? $clog2(n) : 1;
  localparam int CW = $clog2(M+1);

  localparam logic [1:0] ErrOk     = 2'd0;
  localparam logic [1:0] ErrRepeat = 2'd1;
  localparam logic [1:0] ErrNoZero = 2'd2;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   i_q, i_d, j_q, j_d;
  logic [M:0]      seen_q, seen_d;   // bit 0 never used; differences are 1..M
  logic            valid_q, valid_d;
  logic [1:0]      code_q, code_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   diff_q, diff_d;
  logic            snap_en;

  logic [M:0]      res_row [n];
  logic [M:0]      snap_q  [n];
  logic [n-1:0]    has_zero;
  logic            miss_any;
  logic [RW-1:0]   miss_row;
  logic [M:0]      cur_row;
  logic            hit;
  logic [CW-1:0]   diff;
  logic            last;

  for (genvar g = 0; g < n; g++) begin : g_rows
    assign res_row[g]  = res_in[g*(M+1) +: M+1];
    assign has_zero[g] = res_in[g*(M+1)];
  end

  // Lowest row missing mark 0, found by a descending scan so the lowest index wins.
  always_comb begin
    miss_any = 1'b0;
    miss_row = '0;
    for (int r = n - 1; r >= 0; r--) begin
      if (!has_zero[RW'(r)]) begin
        miss_any = 1'b1;
        miss_row = RW'(r);
      end
    end
  end

  assign cur_row = snap_q[r_q];
  assign hit     = cur_row[i_q] & cur_row[j_q];
  assign diff    = j_q - i_q;
  assign last    = (j_q == CW'(M)) && (i_q == CW'(M - 1)) && (r_q == RW'(n - 1));

  // Snapshot of the rulers; only meaningful once a check has been accepted.
  always_ff @(posedge clk) begin
    if (snap_en) snap_q <= res_row;
  end

  // State, pair counters, seen bitmap and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      r_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      seen_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= ErrOk;
      row_q   <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      i_q     <= i_d;
      j_q     <= j_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      row_q   <= row_d;
      diff_q  <= diff_d;
    end
  end

  // Next-state: accept/pre-check in idle, one pair per cycle in scan.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    i_d     = i_q;
    j_d     = j_q;
    seen_d  = seen_q;
    valid_d = valid_q;
    code_d  = code_q;
    row_d   = row_q;
    diff_d  = diff_q;
    snap_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_en = 1'b1;
          seen_d  = '0;
          valid_d = 1'b0;
          code_d  = ErrOk;
          row_d   = '0;
          diff_d  = '0;
          r_d     = '0;
          i_d     = '0;
          j_d     = CW'(1);
          if (miss_any) begin
            state_d = StDone;
            code_d  = ErrNoZero;
            row_d   = miss_row;
          end else begin
            state_d = StScan;
          end
        end
      end
      StScan: begin
        if (hit && seen_q[diff]) begin
          state_d = StDone;
          code_d  = ErrRepeat;
          row_d   = r_q;
          diff_d  = diff;
        end else begin
          if (hit) seen_d[diff] = 1'b1;
          if (last) begin
            state_d = StDone;
            valid_d = 1'b1;
            code_d  = ErrOk;
          end else if (j_q == CW'(M)) begin
            if (i_q == CW'(M - 1)) begin
              r_d = r_q + 1'b1;
              i_d = '0;
              j_d = CW'(1);
            end else begin
              i_d = i_q + 1'b1;
              j_d = i_q + CW'(2);
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state and results.
  always_comb begin
    busy    = (state_q == StScan);
    done    = (state_q == StDone);
    valid   = valid_q;
    errCode = code_q;
    errRow  = row_q;
    errDiff = diff_q;
  end

endmodule
